// File: rtl/alu_pkg.sv
// Shared opcode encoding and width helpers for the pipelined ALU/MAC.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_MUL = 2'b01,
      OP_MAC = 2'b10,
      OP_CLR = 2'b11
   } op_e;

   // Accumulator holds a full product plus guard bits for repeated MACs.
   function automatic int acc_width(input int data_w, input int guard_w);
      return 2 * data_w + guard_w;
   endfunction

endpackage

// File: rtl/alu_mac_pipe_if.sv
// Operand/control and result/debug-tap bundle of the ALU/MAC pipeline.
interface alu_mac_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 38
);
   logic              in_valid;
   logic [1:0]        control;
   logic [DATA_W-1:0] Input1;
   logic [DATA_W-1:0] Input2;
   logic              out_valid;
   logic [ACC_W-1:0]  Output1;
   logic              overflow;
   logic [ACC_W-1:0]  p1_reg;
   logic [ACC_W-1:0]  p2_reg;
   logic [ACC_W-1:0]  p3_reg;

   modport master (
      output in_valid, control, Input1, Input2,
      input  out_valid, Output1, overflow, p1_reg, p2_reg, p3_reg
   );

   modport slave (
      input  in_valid, control, Input1, Input2,
      output out_valid, Output1, overflow, p1_reg, p2_reg, p3_reg
   );
endinterface

// File: rtl/alu_mac_acc.sv
// Stage 3: result register, guard-bit accumulator with saturate/wrap, sticky overflow.
module alu_mac_acc
   import alu_pkg::*;
#(
   parameter int ACC_W    = 38,
   parameter int PROD_W   = 32,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  op_e               op,
   input  logic [PROD_W-1:0] operand,
   output logic              out_valid,
   output logic [ACC_W-1:0]  result,
   output logic [ACC_W-1:0]  acc,
   output logic              overflow
);
   localparam int SUM_W = ACC_W + 1;

   logic [ACC_W-1:0] acc_reg, acc_next;
   logic [ACC_W-1:0] result_reg, result_next;
   logic             ovf_reg, ovf_next;
   logic             valid_reg;
   logic [SUM_W-1:0] sum;

   // One extra bit catches the carry out of the accumulator.
   assign sum = {1'b0, acc_reg} + SUM_W'(operand);

   always_comb begin
      acc_next    = acc_reg;
      ovf_next    = ovf_reg;
      result_next = result_reg;
      if (in_valid) begin
         case (op)
            OP_ADD, OP_MUL: result_next = ACC_W'(operand);
            OP_MAC: begin
               if (sum[ACC_W]) begin
                  acc_next = SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                  ovf_next = 1'b1;
               end else begin
                  acc_next = sum[ACC_W-1:0];
               end
               result_next = acc_next;
            end
            OP_CLR: begin
               acc_next    = '0;
               ovf_next    = 1'b0;
               result_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_reg    <= '0;
         ovf_reg    <= 1'b0;
         result_reg <= '0;
         valid_reg  <= 1'b0;
      end else begin
         acc_reg    <= acc_next;
         ovf_reg    <= ovf_next;
         result_reg <= result_next;
         valid_reg  <= in_valid;
      end
   end

   assign out_valid = valid_reg;
   assign result    = result_reg;
   assign acc       = acc_reg;
   assign overflow  = ovf_reg;
endmodule

// File: rtl/alu_mac_pipe.sv
// Three-stage unsigned ADD/MUL/MAC/CLR pipeline with per-stage debug taps.
module alu_mac_pipe
   import alu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int GUARD_W  = 6,
   parameter bit SATURATE = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   alu_mac_pipe_if.slave  bus
);
   localparam int ACC_W  = acc_width(DATA_W, GUARD_W);
   localparam int PROD_W = 2 * DATA_W;

   logic              s1_valid;
   op_e               s1_op;
   logic [DATA_W-1:0] s1_a, s1_b;

   logic              s2_valid;
   op_e               s2_op;
   logic [PROD_W-1:0] s2_result_reg, s2_result_next;

   logic [ACC_W-1:0]  acc;

   // Operands are captured even on bubbles; only the valid bit qualifies them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else begin
         s1_valid <= bus.in_valid;
         s1_op    <= op_e'(bus.control);
         s1_a     <= bus.Input1;
         s1_b     <= bus.Input2;
      end
   end

   always_comb begin
      s2_result_next = '0;
      case (s1_op)
         OP_ADD:         s2_result_next = PROD_W'(s1_a) + PROD_W'(s1_b);
         OP_MUL, OP_MAC: s2_result_next = PROD_W'(s1_a) * PROD_W'(s1_b);
         default:        s2_result_next = '0;
      endcase
   end

   // Stage-2 register doubles as the inferred multiplier's output register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid      <= 1'b0;
         s2_op         <= OP_ADD;
         s2_result_reg <= '0;
      end else begin
         s2_valid      <= s1_valid;
         s2_op         <= s1_op;
         s2_result_reg <= s2_result_next;
      end
   end

   alu_mac_acc #(
      .ACC_W    (ACC_W),
      .PROD_W   (PROD_W),
      .SATURATE (SATURATE)
   ) u_acc (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s2_valid),
      .op        (s2_op),
      .operand   (s2_result_reg),
      .out_valid (bus.out_valid),
      .result    (bus.Output1),
      .acc       (acc),
      .overflow  (bus.overflow)
   );

   assign bus.p1_reg = ACC_W'({s1_a, s1_b});
   assign bus.p2_reg = ACC_W'(s2_result_reg);
   assign bus.p3_reg = acc;
endmodule

// File: tb/tb_alu_mac_pipe.sv
// Scoreboard bench: saturating and wrapping instances share one directed stimulus stream.
module tb_alu_mac_pipe;
   import alu_pkg::*;

   localparam int DATA_W = 16;
   localparam int ACC_W  = acc_width(16, 6);

   typedef struct {
      int              exp_cyc;
      logic [ACC_W-1:0] out_s, out_w;
      logic            ovf_s, ovf_w;
      logic [ACC_W-1:0] acc_s, acc_w;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0;
   logic [1:0] control = 2'b00;
   logic [DATA_W-1:0] in_a = '0, in_b = '0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t sb[$];
   logic [ACC_W-1:0] last_s = '0, last_w = '0;
   logic [ACC_W-1:0] trk_acc_s = '0, trk_acc_w = '0;

   alu_mac_pipe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if_s ();
   alu_mac_pipe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if_w ();

   assign if_s.in_valid = in_valid;
   assign if_s.control  = control;
   assign if_s.Input1   = in_a;
   assign if_s.Input2   = in_b;
   assign if_w.in_valid = in_valid;
   assign if_w.control  = control;
   assign if_w.Input1   = in_a;
   assign if_w.Input2   = in_b;

   alu_mac_pipe #(.DATA_W(DATA_W), .GUARD_W(6), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .reset(reset), .bus(if_s));
   alu_mac_pipe #(.DATA_W(DATA_W), .GUARD_W(6), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .bus(if_w));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " out_valid"}, {63'd0, if_s.out_valid | if_w.out_valid}, 64'd0);
      chk({tag, " Output1"}, 64'(if_s.Output1 | if_w.Output1), 64'd0);
      chk({tag, " overflow"}, {63'd0, if_s.overflow | if_w.overflow}, 64'd0);
      chk({tag, " taps"}, 64'(if_s.p1_reg | if_s.p2_reg | if_s.p3_reg |
                               if_w.p1_reg | if_w.p2_reg | if_w.p3_reg), 64'd0);
   endtask

   // Monitor: pops the scoreboard whenever a result is presented.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!reset) begin
         chk_all_zero("in_reset");
      end else begin
         chk("valid_match", {63'd0, if_s.out_valid}, {63'd0, if_w.out_valid});
         if (if_s.out_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got 0x%0h expected no result (cycle %0d)",
                        if_s.Output1, cyc);
            end else begin
               e = sb.pop_front();
               chk("latency", 64'(cyc), 64'(e.exp_cyc));
               chk("out_sat", 64'(if_s.Output1), 64'(e.out_s));
               chk("out_wrap", 64'(if_w.Output1), 64'(e.out_w));
               chk("ovf_sat", {63'd0, if_s.overflow}, {63'd0, e.ovf_s});
               chk("ovf_wrap", {63'd0, if_w.overflow}, {63'd0, e.ovf_w});
               chk("acc_sat", 64'(if_s.p3_reg), 64'(e.acc_s));
               chk("acc_wrap", 64'(if_w.p3_reg), 64'(e.acc_w));
               $display("vector cycle %0d: sat=0x%0h wrap=0x%0h ovf=%0b/%0b",
                        cyc, if_s.Output1, if_w.Output1, if_s.overflow, if_w.overflow);
               last_s = e.out_s;
               last_w = e.out_w;
            end
         end else begin
            chk("hold_sat", 64'(if_s.Output1), 64'(last_s));
            chk("hold_wrap", 64'(if_w.Output1), 64'(last_w));
            if (sb.size() > 0 && sb[0].exp_cyc <= cyc) begin
               e = sb.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL missing_result: got no out_valid expected 0x%0h at cycle %0d",
                        e.out_s, e.exp_cyc);
            end
         end
      end
   end

   task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      control  = op;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [ACC_W-1:0] out_s, input logic [ACC_W-1:0] out_w,
                        input logic ovf_s, input logic ovf_w);
      exp_t e;
      drive(op, a, b);
      if (op == OP_MAC || op == OP_CLR) begin
         trk_acc_s = out_s;
         trk_acc_w = out_w;
      end
      e.exp_cyc = cyc + 3;
      e.out_s = out_s;
      e.out_w = out_w;
      e.ovf_s = ovf_s;
      e.ovf_w = ovf_w;
      e.acc_s = trk_acc_s;
      e.acc_w = trk_acc_w;
      sb.push_back(e);
   endtask

   // Bubbles carry a CLR opcode and junk operands that must be ignored.
   task automatic bubble(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         control  = OP_CLR;
         in_a     = 16'hFFFF;
         in_b     = 16'hFFFF;
      end
   endtask

   initial begin
      logic [63:0] t;
      // Ops applied while reset is held must produce nothing.
      for (int i = 0; i < 4; i++) drive(OP_ADD, 16'd1, 16'd1);
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      bubble(1);

      issue(OP_ADD, 16'd1, 16'd1, 38'd2, 38'd2, 1'b0, 1'b0);
      bubble(3);
      issue(OP_MUL, 16'd2, 16'd2, 38'd4, 38'd4, 1'b0, 1'b0);
      issue(OP_MUL, 16'h0700, 16'd1, 38'h700, 38'h700, 1'b0, 1'b0);

      issue(OP_CLR, 16'd9, 16'd9, 38'd0, 38'd0, 1'b0, 1'b0);
      issue(OP_MAC, 16'h0700, 16'd1, 38'h0700, 38'h0700, 1'b0, 1'b0);
      issue(OP_MAC, 16'h0700, 16'd1, 38'h0E00, 38'h0E00, 1'b0, 1'b0);
      issue(OP_MAC, 16'h0700, 16'd1, 38'h1500, 38'h1500, 1'b0, 1'b0);
      issue(OP_MAC, 16'h0700, 16'd1, 38'h1C00, 38'h1C00, 1'b0, 1'b0);

      issue(OP_CLR, 16'd0, 16'd0, 38'd0, 38'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 64; i++) begin
         t = 64'(i) * 64'hFFFE_0001;
         issue(OP_MAC, 16'hFFFF, 16'hFFFF, t[37:0], t[37:0], 1'b0, 1'b0);
      end
      issue(OP_MAC, 16'hFFFF, 16'hFFFF, 38'h3F_FFFF_FFFF, 38'h00_FF7E_0041, 1'b1, 1'b1);
      issue(OP_MAC, 16'hFFFF, 16'hFFFF, 38'h3F_FFFF_FFFF, 38'h01_FF7C_0042, 1'b1, 1'b1);
      issue(OP_MAC, 16'hFFFF, 16'hFFFF, 38'h3F_FFFF_FFFF, 38'h02_FF7A_0043, 1'b1, 1'b1);
      issue(OP_ADD, 16'd5, 16'd6, 38'd11, 38'd11, 1'b1, 1'b1);
      issue(OP_CLR, 16'd0, 16'd0, 38'd0, 38'd0, 1'b0, 1'b0);
      issue(OP_MAC, 16'h0010, 16'h0010, 38'h100, 38'h100, 1'b0, 1'b0);
      bubble(4);

      // Three MACs in flight when reset hits: none may retire.
      drive(OP_MAC, 16'hFFFF, 16'hFFFF);
      drive(OP_MAC, 16'hFFFF, 16'hFFFF);
      drive(OP_MAC, 16'hFFFF, 16'hFFFF);
      #2;
      reset = 1'b0;
      sb.delete();
      last_s = '0;
      last_w = '0;
      trk_acc_s = '0;
      trk_acc_w = '0;
      #1;
      chk_all_zero("async_reset");
      bubble(2);
      reset = 1'b1;

      issue(OP_MAC, 16'd3, 16'd4, 38'hC, 38'hC, 1'b0, 1'b0);
      bubble(1);
      issue(OP_MAC, 16'd1, 16'd1, 38'hD, 38'hD, 1'b0, 1'b0);
      bubble(2);
      issue(OP_MAC, 16'd2, 16'd2, 38'h11, 38'h11, 1'b0, 1'b0);
      bubble(1);
      issue(OP_ADD, 16'hFFFF, 16'hFFFF, 38'h1_FFFE, 38'h1_FFFE, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      chk("p1_tap", 64'(if_s.p1_reg), 64'h00_FFFF_FFFF);
      bubble(1);
      @(posedge clk);
      #2;
      chk("p2_tap", 64'(if_s.p2_reg), 64'h1_FFFE);

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      bubble(2);
      chk("drain", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/alu_mac_pipe.md
# alu_mac_pipe

Parametrised, fully pipelined arithmetic unit that succeeds the fixed-width 16-bit ALU in the lab datapath. It performs add, multiply, multiply-accumulate and accumulator-clear on unsigned operands. It has a valid-qualified three-stage pipeline, a guard-bit accumulator with optional saturation, and exported per-stage debug taps. It sits between the operand source (switch/test-bench stimulus) and the result display/capture logic.

## Interface
- DATA_W, 16, operand width in bits.
- GUARD_W, 6, accumulator guard bits; ACC_W = 2*DATA_W + GUARD_W (38 at defaults).
- SATURATE, 1, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_W.

- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operands/control valid this cycle.
- control  in  2  opcode: 00 ADD, 01 MUL, 10 MAC, 11 CLR.
- Input1  in  DATA_W  operand A, unsigned.
- Input2  in  DATA_W  operand B, unsigned.
- out_valid  out  1  Output1 holds a new result.
- Output1  out  ACC_W  result register.
- overflow  out  1  sticky accumulator overflow flag.
- p1_reg  out  ACC_W  stage-1 tap: {Input1, Input2} zero-extended.
- p2_reg  out  ACC_W  stage-2 tap: raw sum or product, zero-extended.
- p3_reg  out  ACC_W  stage-3 tap: internal accumulator value.

## Operation
- Stage 1 registers the operands, the opcode and in_valid. Stage 2 computes A+B (ADD) or A*B (MUL, MAC); CLR passes 0. Stage 3 writes the result and updates the accumulator.
- ADD: Output1 = zero-extended A+B (DATA_W+1 bits meaningful). Accumulator unchanged.
- MUL: Output1 = zero-extended A*B. Accumulator unchanged.
- MAC: acc_next = acc + A*B, computed at ACC_W+1 bits. If bit ACC_W is set:
  - SATURATE=1: acc = 2^ACC_W-1.
  - SATURATE=0: acc wraps.
  - In both cases overflow is set.
  - Output1 = acc_next (post-clamp).
- CLR: acc = 0, overflow = 0, Output1 = 0.
- Bubbles (in_valid=0) flow through the pipeline. On a bubble, stage 3 holds Output1 and the accumulator, and out_valid = 0.
- Ops retire strictly in order. A CLR immediately followed by a MAC accumulates from 0; no hazard is possible because only stage 3 reads or writes the accumulator.
- Once saturated, the accumulator stays at the maximum under further MACs. overflow stays set until CLR or reset.

## Timing
- Latency is 3 cycles: an op sampled at edge N appears on Output1 with out_valid=1 after edge N+2, i.e. in the cycle after the third rising edge.
- Throughput is one op per cycle. Back-to-back MACs each accumulate; there are no stall cycles. No backpressure input exists.
- Reset assertion at any time immediately forces:
  - all pipeline valids, out_valid, Output1, accumulator, overflow and p1/p2/p3 taps = 0.
- In-flight ops are discarded.
- After reset deasserts, the first op sampled produces its result 3 cycles later as normal.
- Simultaneous overflow and CLR cannot occur in the same stage. CLR always wins over a prior sticky overflow.

## Structure
- Shared package alu_pkg holds the opcode constants (OP_ADD=2'b00, OP_MUL=2'b01, OP_MAC=2'b10, OP_CLR=2'b11) and the ACC_W derivation function.
- One sub-module is natural: alu_mac_acc. It contains the stage-3 accumulator with saturation/wrap logic and the sticky overflow flag, parametrised by ACC_W and SATURATE.
- The multiplier is inferred (DSP). Stage 2 is its register boundary, so no vendor IP core is instantiated.

## Test plan
- Reset held low, ops applied → all outputs stay 0. Release reset, ADD 1+1 → Output1 = 2, out_valid pulses 3 cycles later.
- MUL 2*2 then MUL 0x0700*1 back-to-back → Output1 = 4 then 0x700 on consecutive cycles; accumulator stays 0.
- CLR, then MAC 0x0700*1 ×4 every cycle → Output1 = 0x700, 0xE00, 0x1500, 0x1C00; overflow = 0.
- SATURATE=1, CLR, then 65 × MAC 0xFFFF*0xFFFF:
  - after 64 ops Output1 = 0x3F_FF80_0040;
  - after 65 ops Output1 = 0x3F_FFFF_FFFF and overflow = 1;
  - overflow persists until CLR.
- SATURATE=0, same sequence → 65th result = 0x3F_FF80_0040 + 0xFFFE_0001 mod 2^38 = 0x00_FF7E_0041; overflow = 1.
- Reset pulsed while 3 MACs are in flight, and bubbles interleaved in a later run:
  - in-flight results never appear;
  - accumulator restarts at 0;
  - out_valid is low on the bubbles and Output1 holds.
